// File: rtl/dlk_alloc_tracker.sv
// dlk_alloc_tracker
// Watches the single-issue commit stream for calls into the allocator routine,
// waits for the matching return and forwards the returned pointer (a0) to the
// DLK base-address buffer as a one-cycle write. Abandoned or superseded calls
// and successful writes are counted in saturating debug counters.
module dlk_alloc_tracker #(
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             rst_us,
   input  logic [31:0]      malloc_addr_i,
   input  logic             commit_valid_i,
   input  logic [31:0]      commit_pc_i,
   input  logic             commit_is_call_i,
   input  logic [31:0]      commit_target_i,
   input  logic [31:0]      a0_i,
   output logic             en_write_o,
   output logic [31:0]      base_addr_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] alloc_cnt_o,
   output logic [CNT_W-1:0] drop_cnt_o
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] WAIT_RET = 1'b1;

   // Counter index 0 counts emitted writes, index 1 counts dropped calls.
   localparam int NUM_CNT = 2;

   logic [0:0]       state_reg, state_next;
   logic [31:0]      ret_pc_reg, ret_pc_next;
   logic [TMR_W-1:0] timer_reg, timer_next;
   logic             en_write_reg, en_write_next;
   logic [31:0]      base_addr_reg, base_addr_next;
   logic [NUM_CNT-1:0] cnt_inc;
   logic [CNT_W-1:0] cnt_val [NUM_CNT];

   logic call_ev;
   logic ret_ev;
   logic tmr_expired;

   assign call_ev     = commit_valid_i && commit_is_call_i && (commit_target_i == malloc_addr_i);
   assign ret_ev      = commit_valid_i && (commit_pc_i == ret_pc_reg);
   assign tmr_expired = (timer_reg == TMR_LAST);

   // Next-state logic: return beats a simultaneous timeout; a call while
   // waiting replaces the pending one and counts it as dropped.
   always_comb begin
      state_next     = state_reg;
      ret_pc_next    = ret_pc_reg;
      timer_next     = timer_reg;
      en_write_next  = 1'b0;
      base_addr_next = base_addr_reg;
      cnt_inc        = '0;
      case (state_reg)
         IDLE: begin
            if (call_ev) begin
               state_next  = WAIT_RET;
               ret_pc_next = commit_pc_i + 32'd4;
               timer_next  = '0;
            end
         end
         default: begin
            timer_next = timer_reg + TMR_W'(1);
            if (ret_ev) begin
               state_next = IDLE;
               if (a0_i != 32'd0) begin
                  en_write_next  = 1'b1;
                  base_addr_next = a0_i;
                  cnt_inc[0]     = 1'b1;
               end
            end else if (call_ev) begin
               ret_pc_next = commit_pc_i + 32'd4;
               timer_next  = '0;
               cnt_inc[1]  = 1'b1;
            end else if (tmr_expired) begin
               state_next = IDLE;
               cnt_inc[1] = 1'b1;
            end
         end
      endcase
   end

   // Tracker state and output registers; debug clear behaves like reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         ret_pc_reg    <= '0;
         timer_reg     <= '0;
         en_write_reg  <= 1'b0;
         base_addr_reg <= '0;
      end else if (rst_us) begin
         state_reg     <= IDLE;
         ret_pc_reg    <= '0;
         timer_reg     <= '0;
         en_write_reg  <= 1'b0;
         base_addr_reg <= '0;
      end else begin
         state_reg     <= state_next;
         ret_pc_reg    <= ret_pc_next;
         timer_reg     <= timer_next;
         en_write_reg  <= en_write_next;
         base_addr_reg <= base_addr_next;
      end
   end

   for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Saturating event counter: holds at all-ones instead of wrapping.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_reg <= '0;
         end else if (rst_us) begin
            cnt_reg <= '0;
         end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end

      assign cnt_val[gi] = cnt_reg;
   end

   assign en_write_o  = en_write_reg;
   assign base_addr_o = base_addr_reg;
   assign busy_o      = (state_reg == WAIT_RET);
   assign alloc_cnt_o = cnt_val[0];
   assign drop_cnt_o  = cnt_val[1];

endmodule

// File: tb/tb_dlk_alloc_tracker.sv
// Bench for dlk_alloc_tracker: a vector table for the main call/return
// flow plus hand-written sequences for timeout, debug clear and async reset.
// Expected writes go through a queue that is drained one entry per cycle.
module tb_dlk_alloc_tracker;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 2;
   localparam logic [31:0] M = 32'h8000_1000;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             rst_us;
   logic [31:0]      malloc_addr_i;
   logic             commit_valid_i;
   logic [31:0]      commit_pc_i;
   logic             commit_is_call_i;
   logic [31:0]      commit_target_i;
   logic [31:0]      a0_i;
   logic             en_write_o;
   logic [31:0]      base_addr_o;
   logic             busy_o;
   logic [CNT_W-1:0] alloc_cnt_o;
   logic [CNT_W-1:0] drop_cnt_o;

   dlk_alloc_tracker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .rst_us           (rst_us),
      .malloc_addr_i    (malloc_addr_i),
      .commit_valid_i   (commit_valid_i),
      .commit_pc_i      (commit_pc_i),
      .commit_is_call_i (commit_is_call_i),
      .commit_target_i  (commit_target_i),
      .a0_i             (a0_i),
      .en_write_o       (en_write_o),
      .base_addr_o      (base_addr_o),
      .busy_o           (busy_o),
      .alloc_cnt_o      (alloc_cnt_o),
      .drop_cnt_o       (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic        call;
      logic [31:0] tgt;
      logic [31:0] a0;
      logic        wr;
      logic [31:0] base;
      logic        busy;
      logic [1:0]  alloc;
      logic [1:0]  drop;
   } vec_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] base;
   } wr_t;

   vec_t vecs [19];
   wr_t  wr_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(logic v, logic [31:0] pc, logic call, logic [31:0] tgt,
                               logic [31:0] a0, logic wr, logic [31:0] base, logic busy,
                               logic [1:0] alloc, logic [1:0] drop);
      vec_t r;
      r.v = v; r.pc = pc; r.call = call; r.tgt = tgt; r.a0 = a0;
      r.wr = wr; r.base = base; r.busy = busy; r.alloc = alloc; r.drop = drop;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock of stimulus; the expected write outcome is queued when the
   // inputs are driven and popped when the registered output appears.
   task automatic step(input logic rst, input logic v, input logic [31:0] pc, input logic call,
                       input logic [31:0] tgt, input logic [31:0] a0,
                       input logic exp_wr, input logic [31:0] exp_base, input string tag);
      wr_t e;
      rst_us           = rst;
      commit_valid_i   = v;
      commit_pc_i      = pc;
      commit_is_call_i = call;
      commit_target_i  = tgt;
      a0_i             = a0;
      wr_q.push_back({exp_wr, exp_base});
      @(posedge clk_i);
      #1;
      e = wr_q.pop_front();
      chk({tag, " en_write"}, 32'(en_write_o), 32'(e.wr));
      if (e.wr) chk({tag, " base_addr"}, base_addr_o, e.base);
      $display("%s: pc=%h call=%b a0=%h -> en_write=%b base=%h busy=%b alloc=%0d drop=%0d",
               tag, pc, v & call, a0, en_write_o, base_addr_o, busy_o, alloc_cnt_o, drop_cnt_o);
      rst_us = 1'b0;
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, tag);
   endtask

   task automatic chk_state(input string tag, input logic busy, input logic [1:0] alloc,
                            input logic [1:0] drop);
      chk({tag, " busy"}, 32'(busy_o), 32'(busy));
      chk({tag, " alloc_cnt"}, 32'(alloc_cnt_o), 32'(alloc));
      chk({tag, " drop_cnt"}, 32'(drop_cnt_o), 32'(drop));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1, 32'h8000_0100, 0, 32'h0,         32'h1111,      0, 32'h0,         0, 0, 0);
      vecs[1]  = mk(1, 32'h8000_0200, 1, M,             32'h0,         0, 32'h0,         1, 0, 0);
      vecs[2]  = mk(1, 32'h8000_0100, 0, 32'h0,         32'h2222,      0, 32'h0,         1, 0, 0);
      vecs[3]  = mk(1, 32'h8000_0204, 0, 32'h0,         32'h8002_0040, 1, 32'h8002_0040, 0, 1, 0);
      vecs[4]  = mk(1, 32'h8000_0200, 1, M,             32'h0,         0, 32'h8002_0040, 1, 1, 0);
      vecs[5]  = mk(1, 32'h8000_0204, 0, 32'h0,         32'h0,         0, 32'h8002_0040, 0, 1, 0);
      vecs[6]  = mk(1, 32'h8000_0200, 1, M,             32'h0,         0, 32'h8002_0040, 1, 1, 0);
      vecs[7]  = mk(1, 32'h8000_0300, 1, M,             32'h0,         0, 32'h8002_0040, 1, 1, 1);
      vecs[8]  = mk(1, 32'h8000_0204, 0, 32'h0,         32'h1234,      0, 32'h8002_0040, 1, 1, 1);
      vecs[9]  = mk(1, 32'h8000_0304, 0, 32'h0,         32'h8002_0100, 1, 32'h8002_0100, 0, 2, 1);
      vecs[10] = mk(1, 32'h8000_0400, 1, 32'h8000_2000, 32'h0,         0, 32'h8002_0100, 0, 2, 1);
      vecs[11] = mk(0, 32'h8000_0400, 1, M,             32'h0,         0, 32'h8002_0100, 0, 2, 1);
      vecs[12] = mk(1, 32'h8000_0500, 0, M,             32'h0,         0, 32'h8002_0100, 0, 2, 1);
      vecs[13] = mk(1, 32'hFFFF_FFFC, 1, M,             32'h0,         0, 32'h8002_0100, 1, 2, 1);
      vecs[14] = mk(1, 32'h0000_0000, 0, 32'h0,         32'h10,        1, 32'h10,        0, 3, 1);
      vecs[15] = mk(1, 32'h8000_0200, 1, M,             32'h0,         0, 32'h10,        1, 3, 1);
      vecs[16] = mk(1, 32'h8000_0204, 0, 32'h0,         32'h8002_0080, 1, 32'h8002_0080, 0, 3, 1);
      vecs[17] = mk(1, 32'h8000_0200, 1, M,             32'h0,         0, 32'h8002_0080, 1, 3, 1);
      vecs[18] = mk(1, 32'h8000_0204, 0, 32'h0,         32'h44,        1, 32'h44,        0, 3, 1);

      rst_ni = 1'b0; rst_us = 1'b0; malloc_addr_i = M;
      commit_valid_i = 1'b0; commit_pc_i = '0; commit_is_call_i = 1'b0;
      commit_target_i = '0; a0_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset en_write", 32'(en_write_o), 32'h0);
      chk("reset base_addr", base_addr_o, 32'h0);
      chk_state("reset", 1'b0, 2'd0, 2'd0);
      rst_ni = 1'b1;

      // Main flow: return, failed alloc, nested call, wrap, saturation.
      for (int i = 0; i < 19; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step(1'b0, vecs[i].v, vecs[i].pc, vecs[i].call, vecs[i].tgt, vecs[i].a0,
              vecs[i].wr, vecs[i].base, tag);
         chk({tag, " base_hold"}, base_addr_o, vecs[i].base);
         chk_state(tag, vecs[i].busy, vecs[i].alloc, vecs[i].drop);
      end

      // Debug clear returns everything to reset values.
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "rst_us");
      chk("rst_us base_addr", base_addr_o, 32'h0);
      chk_state("rst_us", 1'b0, 2'd0, 2'd0);

      // Timeout: busy stays high for exactly TIMEOUT cycles.
      step(1'b0, 1'b1, 32'h8000_0200, 1'b1, M, 32'h0, 1'b0, 32'h0, "to_call");
      chk_state("to_call", 1'b1, 2'd0, 2'd0);
      for (int k = 1; k < TIMEOUT; k++) begin
         idle($sformatf("to_wait%0d", k));
         chk_state($sformatf("to_wait%0d", k), 1'b1, 2'd0, 2'd0);
      end
      idle("to_expire");
      chk_state("to_expire", 1'b0, 2'd0, 2'd1);
      step(1'b0, 1'b1, 32'h8000_0204, 1'b0, 32'h0, 32'h8002_0040, 1'b0, 32'h0, "to_late_ret");
      chk_state("to_late_ret", 1'b0, 2'd0, 2'd1);

      // Return on the last cycle before expiry beats the timeout.
      step(1'b0, 1'b1, 32'h8000_0200, 1'b1, M, 32'h0, 1'b0, 32'h0, "edge_call");
      for (int k = 1; k < TIMEOUT; k++) idle($sformatf("edge_wait%0d", k));
      chk_state("edge_wait_end", 1'b1, 2'd0, 2'd1);
      step(1'b0, 1'b1, 32'h8000_0204, 1'b0, 32'h0, 32'h55, 1'b1, 32'h55, "edge_ret");
      chk_state("edge_ret", 1'b0, 2'd1, 2'd1);

      // Changing the allocator entry while waiting leaves ret_pc alone.
      step(1'b0, 1'b1, 32'h8000_0200, 1'b1, M, 32'h0, 1'b0, 32'h0, "chg_call");
      malloc_addr_i = 32'h9000_0000;
      idle("chg_wait");
      step(1'b0, 1'b1, 32'h8000_0204, 1'b0, 32'h0, 32'h66, 1'b1, 32'h66, "chg_ret");
      chk_state("chg_ret", 1'b0, 2'd2, 2'd1);
      malloc_addr_i = M;

      // Debug clear in WAIT_RET abandons the call.
      step(1'b0, 1'b1, 32'h8000_0200, 1'b1, M, 32'h0, 1'b0, 32'h0, "clr_call");
      chk_state("clr_call", 1'b1, 2'd2, 2'd1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "clr_pulse");
      chk_state("clr_pulse", 1'b0, 2'd0, 2'd0);
      step(1'b0, 1'b1, 32'h8000_0204, 1'b0, 32'h0, 32'h8002_0040, 1'b0, 32'h0, "clr_ret");
      chk_state("clr_ret", 1'b0, 2'd0, 2'd0);

      // Debug clear coinciding with the return suppresses the write.
      step(1'b0, 1'b1, 32'h8000_0200, 1'b1, M, 32'h0, 1'b0, 32'h0, "clr2_call");
      step(1'b1, 1'b1, 32'h8000_0204, 1'b0, 32'h0, 32'h77, 1'b0, 32'h0, "clr2_ret");
      chk("clr2_ret base_addr", base_addr_o, 32'h0);
      chk_state("clr2_ret", 1'b0, 2'd0, 2'd0);

      // Asynchronous reset mid-WAIT_RET takes effect without a clock edge.
      step(1'b0, 1'b1, 32'h8000_0200, 1'b1, M, 32'h0, 1'b0, 32'h0, "arst_call");
      step(1'b0, 1'b1, 32'h8000_0204, 1'b0, 32'h0, 32'h88, 1'b1, 32'h88, "arst_ret");
      step(1'b0, 1'b1, 32'h8000_0200, 1'b1, M, 32'h0, 1'b0, 32'h0, "arst_call2");
      chk_state("arst_call2", 1'b1, 2'd1, 2'd0);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst base_addr", base_addr_o, 32'h0);
      chk_state("arst", 1'b0, 2'd0, 2'd0);
      $display("arst: async reset asserted mid-cycle, busy=%b", busy_o);
      #1 rst_ni = 1'b1;
      step(1'b0, 1'b1, 32'h8000_0204, 1'b0, 32'h0, 32'h99, 1'b0, 32'h0, "arst_ret2");
      chk_state("arst_ret2", 1'b0, 2'd0, 2'd0);

      chk("scoreboard leftover", 32'(wr_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
